// File: rtl/viterbi_acs.sv
// Add-compare-select stage for the rate-1/2, K=3 (7,5) hard-decision Viterbi decoder.
// Optional metric normalization is enabled by defining VITERBI_ACS_NORM_EN.
module viterbi_acs #(
  parameter int FRAME_LEN = 8,
  parameter int PM_W      = 6,
  parameter int INIT_PM   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [1:0]      rx_sym,
  output logic            in_ready,
  output logic            prv_st_00,
  output logic            prv_st_01,
  output logic            prv_st_10,
  output logic            prv_st_11,
  output logic            en_mem,
  output logic [PM_W-1:0] pm_00,
  output logic [PM_W-1:0] pm_01,
  output logic [PM_W-1:0] pm_10,
  output logic [PM_W-1:0] pm_11,
  output logic [1:0]      best_st,
  output logic            frame_done,
  output logic [1:0]      dbg_state
);

  // Handshake: a symbol is consumed on a rising clk where in_valid && in_ready;
  // in_ready depends only on the FSM state, never on in_valid.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PM_W-1:0]   pm_q [4];
  logic [PM_W-1:0]   pm_d [4];
  logic [3:0]        prv_q, prv_d;
  logic [1:0]        best_q, best_d;
  logic              en_mem_q, en_mem_d;
  logic              done_q, done_d;

  logic [PM_W-1:0]   acs_pm [4];
  logic [PM_W-1:0]   upd_pm [4];
  logic [3:0]        acs_dec;
  logic [1:0]        best_v;
  logic [PM_W-1:0]   min_v;

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] sum;
    sum = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
  endfunction

  // Hamming distance between rx and the branch label entering ns from predecessor {ns[0], k}.
  function automatic logic [1:0] branch_bm(input logic [1:0] ns, input logic k,
                                           input logic [1:0] rx);
    logic c0, c1;
    c0 = ns[1] ^ ns[0] ^ k;
    c1 = ns[1] ^ k;
    return {1'b0, rx[1] ^ c0} + {1'b0, rx[0] ^ c1};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam logic [1:0] NS = 2'(g);
    logic [PM_W-1:0] cand0, cand1;
    assign cand0      = sat_add(pm_q[{NS[0], 1'b0}], branch_bm(NS, 1'b0, rx_sym));
    assign cand1      = sat_add(pm_q[{NS[0], 1'b1}], branch_bm(NS, 1'b1, rx_sym));
    assign acs_dec[g] = (cand1 < cand0);
    assign acs_pm[g]  = acs_dec[g] ? cand1 : cand0;
  end

`ifdef VITERBI_ACS_NORM_EN
  logic all_hi;
  assign all_hi = acs_pm[0][PM_W-1] & acs_pm[1][PM_W-1] & acs_pm[2][PM_W-1] & acs_pm[3][PM_W-1];

  // Common subtraction of 2^(PM_W-1) keeps every ordering, so decisions and best_st are unaffected.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      upd_pm[i] = acs_pm[i];
      if (all_hi) upd_pm[i][PM_W-1] = 1'b0;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) upd_pm[i] = acs_pm[i];
  end
`endif

  always_comb begin
    best_v = 2'd0;
    min_v  = acs_pm[0];
    for (int i = 1; i < 4; i++) begin
      if (acs_pm[i] < min_v) begin
        min_v  = acs_pm[i];
        best_v = 2'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pm_d     = pm_q;
    prv_d    = prv_q;
    best_d   = best_q;
    en_mem_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pm_d[0] = '0;
          pm_d[1] = INIT_V;
          pm_d[2] = INIT_V;
          pm_d[3] = INIT_V;
          best_d  = 2'd0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          pm_d     = upd_pm;
          prv_d    = acs_dec;
          best_d   = best_v;
          en_mem_d = 1'b1;
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // First DRAIN cycle still shows the last decision; FRAME_LEN traceback cycles follow it.
        if (cnt_q == CNT_W'(FRAME_LEN)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          en_mem_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pm_q[0]  <= '0;
      pm_q[1]  <= INIT_V;
      pm_q[2]  <= INIT_V;
      pm_q[3]  <= INIT_V;
      prv_q    <= '0;
      best_q   <= 2'd0;
      en_mem_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pm_q     <= pm_d;
      prv_q    <= prv_d;
      best_q   <= best_d;
      en_mem_q <= en_mem_d;
      done_q   <= done_d;
    end
  end

  assign in_ready   = (state_q == S_RUN);
  assign prv_st_00  = prv_q[0];
  assign prv_st_01  = prv_q[1];
  assign prv_st_10  = prv_q[2];
  assign prv_st_11  = prv_q[3];
  assign en_mem     = en_mem_q;
  assign pm_00      = pm_q[0];
  assign pm_01      = pm_q[1];
  assign pm_10      = pm_q[2];
  assign pm_11      = pm_q[3];
  assign best_st    = best_q;
  assign frame_done = done_q;
  assign dbg_state  = state_q;

endmodule
